// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues single outstanding imem requests, buffers one instruction.
// Latency: request cycle + memory latency (>=1) -> inst_valid the cycle after imem_valid; best case 1 inst / 2 cycles.
// Backpressure: stall holds the buffered instruction and blocks new requests; redirect flushes and overrides stall.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [15:0] redirect_addr,
    input  logic        stall,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    output logic [15:0] inst_out,
    output logic [15:0] pc_out,
    output logic [15:0] pc_plus2,
    output logic        inst_valid,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_READY   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2,
        ST_HALTED  = 2'd3
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] inst_q;
    logic [15:0] pc_out_q;
    logic        inst_valid_q;
    logic        halted_q;

    logic buf_free;
    logic buf_hlt;
    logic load;
    logic consume;

    // A buffered HLT must never be followed by a request, even in the cycle it is consumed.
    assign buf_free = !inst_valid_q || !stall;
    assign buf_hlt  = inst_valid_q && (inst_q[15:12] == HALT_OPCODE);
    assign imem_req = (state_q == ST_READY) && !redirect && !rst && buf_free && !buf_hlt;
    assign imem_addr = pc_q;

    // Response accepted into the buffer; consumption only counts when nothing overrides it.
    assign load    = (state_q == ST_WAIT) && imem_valid && !redirect;
    assign consume = inst_valid_q && !stall && !redirect && !load;

    assign inst_out   = inst_q;
    assign pc_out     = pc_out_q;
    assign pc_plus2   = pc_out_q + 16'd2;
    assign inst_valid = inst_valid_q;
    assign halted     = halted_q;

    // Fetch FSM plus PC and instruction buffer; later assignments encode priority (redirect last, so it wins).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_READY;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            pc_out_q     <= '0;
            inst_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_READY: begin
                    if (imem_req) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_valid) begin
                        // A response racing a redirect belongs to the wrong path and is simply dropped.
                        if (!redirect) begin
                            inst_q       <= imem_data;
                            pc_out_q     <= pc_q;
                            pc_q         <= pc_q + 16'd2;
                            inst_valid_q <= 1'b1;
                        end
                        state_q <= ST_READY;
                    end else if (redirect) begin
                        state_q <= ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (imem_valid) begin
                        state_q <= ST_READY;
                    end
                end
                ST_HALTED: begin
                    if (redirect) begin
                        state_q  <= ST_READY;
                        halted_q <= 1'b0;
                    end
                end
                default: state_q <= ST_READY;
            endcase

            if (consume) begin
                inst_valid_q <= 1'b0;
                if (inst_q[15:12] == HALT_OPCODE) begin
                    state_q  <= ST_HALTED;
                    halted_q <= 1'b1;
                end
            end

            if (redirect) begin
                pc_q         <= redirect_addr;
                inst_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer against a transaction-level reference model.
// Memory responder answers each observed request after a random latency; inputs are driven at negedge.
// Outputs are compared #1 after negedge, before the next rising edge.
module tb_fetch_sequencer;

    localparam logic [15:0] RST_PC = 16'hFFFE;
    localparam logic [3:0]  HLT    = 4'hF;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        stall;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic [15:0] inst_out;
    logic [15:0] pc_out;
    logic [15:0] pc_plus2;
    logic        inst_valid;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural PC, a one-entry buffer, halt flag, and the outstanding-request bookkeeping.
    logic [15:0] m_pc;
    logic [15:0] m_inst;
    logic [15:0] m_ipc;
    logic        m_vld;
    logic        m_halted;
    logic        m_out;
    logic        m_stale;
    logic        exp_req;
    logic        resp;
    int          n_loads;
    int          n_halts;
    int          n_drops;

    // Memory environment state.
    int          pend_cnt;
    logic [15:0] pend_addr;
    int          phase;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .RESET_PC   (RST_PC),
        .HALT_OPCODE(HLT)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_valid   (imem_valid),
        .imem_data    (imem_data),
        .inst_out     (inst_out),
        .pc_out       (pc_out),
        .pc_plus2     (pc_plus2),
        .inst_valid   (inst_valid),
        .halted       (halted)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Program image: HLT sits at addresses whose bits [6:1] equal 9 (e.g. 0x0012); nothing else uses opcode F.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [3:0] op;
        if (a[6:1] == 6'd9) return {HLT, a[11:0]};
        op = a[4:1];
        if (op == HLT) op = 4'hE;
        return {op, a[11:0] ^ 12'hA5C};
    endfunction

    task automatic model_reset();
        m_pc     = RST_PC;
        m_inst   = 16'h0000;
        m_ipc    = 16'h0000;
        m_vld    = 1'b0;
        m_halted = 1'b0;
        m_out    = 1'b0;
        m_stale  = 1'b0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        if (rst) begin
            model_reset();
            return;
        end
        resp = imem_valid && m_out;
        if (redirect) begin
            m_pc     = redirect_addr;
            m_vld    = 1'b0;
            m_halted = 1'b0;
            if (resp) begin
                m_out   = 1'b0;
                m_stale = 1'b0;
                n_drops++;
            end else if (m_out) begin
                m_stale = 1'b1;
            end
        end else begin
            if (resp && !m_stale) begin
                m_inst = imem_data;
                m_ipc  = m_pc;
                m_pc   = m_pc + 16'd2;
                m_vld  = 1'b1;
                n_loads++;
            end else if (m_vld && !stall) begin
                m_vld = 1'b0;
                if (m_inst[15:12] == HLT) begin
                    m_halted = 1'b1;
                    n_halts++;
                end
            end
            if (resp) begin
                if (m_stale) n_drops++;
                m_out   = 1'b0;
                m_stale = 1'b0;
            end
            if (exp_req) m_out = 1'b1;
        end
    endtask

    initial begin
        rst           = 1'b1;
        redirect      = 1'b0;
        redirect_addr = 16'h0000;
        stall         = 1'b0;
        imem_valid    = 1'b0;
        imem_data     = 16'h0000;
        pend_cnt      = 0;
        pend_addr     = 16'h0000;
        n_loads       = 0;
        n_halts       = 0;
        n_drops       = 0;
        model_reset();

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            phase = (cyc / 250) % 4;

            // Stimulus mix per phase: clean streaming, heavy stall, heavy redirect, mixed with resets.
            rst = (cyc < 2) || (phase == 3 && $urandom_range(0, 199) == 0);
            case (phase)
                0:       begin stall = 1'b0;                         redirect = ($urandom_range(0, 49) == 0); end
                1:       begin stall = ($urandom_range(0, 9) < 6);   redirect = ($urandom_range(0, 29) == 0); end
                2:       begin stall = ($urandom_range(0, 4) == 0);  redirect = ($urandom_range(0, 4) == 0);  end
                default: begin stall = ($urandom_range(0, 9) < 3);   redirect = ($urandom_range(0, 19) == 0); end
            endcase
            case ($urandom_range(0, 4))
                0:       redirect_addr = 16'h0008;
                1:       redirect_addr = 16'hFFFC;
                2:       redirect_addr = 16'h0100;
                default: redirect_addr = 16'($urandom);
            endcase

            // Memory: deliver a due response; otherwise occasionally strobe imem_valid while idle.
            imem_valid = 1'b0;
            imem_data  = 16'h0000;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    imem_valid = 1'b1;
                    imem_data  = mem_word(pend_addr);
                end
            end else if (!m_out && $urandom_range(0, 19) == 0) begin
                imem_valid = 1'b1;
                imem_data  = 16'hF0AD;
            end

            #1;
            exp_req = !rst && !redirect && !m_halted && !m_out && (!m_vld || !stall)
                      && !(m_vld && m_inst[15:12] == HLT);
            chk("imem_req", 16'(imem_req), 16'(exp_req));
            if (exp_req) chk("imem_addr", imem_addr, m_pc);
            chk("inst_valid", 16'(inst_valid), 16'(m_vld));
            chk("halted", 16'(halted), 16'(m_halted));
            chk("inst_out", inst_out, m_inst);
            chk("pc_out", pc_out, m_ipc);
            chk("pc_plus2", pc_plus2, m_ipc + 16'd2);

            if (rst) begin
                pend_cnt = 0;
            end else if (imem_req) begin
                pend_addr = imem_addr;
                pend_cnt  = ($urandom_range(0, 7) == 0) ? $urandom_range(3, 8) : $urandom_range(1, 2);
            end

            model_step();
        end

        // The random run must actually have exercised loads, halts and dropped responses.
        chk("loads_seen", 16'(n_loads > 100), 16'd1);
        chk("halts_seen", 16'(n_halts > 0), 16'd1);
        chk("drops_seen", 16'(n_drops > 0), 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the instruction-fetch side of the 16-bit core.
- Owns the architectural PC register and issues requests to a multi-cycle instruction memory.
- Buffers one fetched instruction toward the IF/ID latch.
- Applies branch redirects (taken target from the PC next-address logic) and stops fetching after a HLT instruction is consumed.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
HALT_OPCODE, 4'hF, value of inst[15:12] that identifies HLT

Ports:
clk  input  1  core clock
rst  input  1  synchronous, active-high reset
redirect  input  1  branch taken/resolved; load redirect_addr
redirect_addr  input  16  branch target
stall  input  1  IF/ID cannot accept this cycle
imem_req  output  1  one-cycle request pulse; memory latches imem_addr
imem_addr  output  16  fetch address (= pc)
imem_valid  input  1  one-cycle response strobe
imem_data  input  16  instruction word, valid with imem_valid
inst_out  output  16  buffered instruction
pc_out  output  16  address of inst_out
pc_plus2  output  16  pc_out + 2 (mod 2^16)
inst_valid  output  1  inst_out valid; consumed when inst_valid && !stall
halted  output  1  HLT consumed; fetch stopped

Behaviour:
- Reset: one clock and one reset, as already decided; rst is synchronous and active-high.
  - Effects while rst is high: state=READY, pc=RESET_PC, inst_valid=0, halted=0, inst_out=0, pc_out=0.
  - imem_req=0 while rst is high.
  - Mid-operation reset abandons any outstanding request. The memory shares rst, so no stale response follows.
- States:
  - READY: no request outstanding.
  - WAIT: one request outstanding.
  - DISCARD: the outstanding request is stale.
  - HALTED: fetch stopped.
- Buffer free this cycle means !inst_valid || !stall.
- imem_req (combinational) = state==READY && !redirect && !rst && buffer free && !(inst_valid && inst_out[15:12]==HALT_OPCODE). imem_addr = pc.
- READY: on imem_req, go to WAIT. Otherwise stay.
- WAIT, imem_valid && !redirect:
  - inst_out<=imem_data, pc_out<=pc, pc_plus2<=pc+2, inst_valid<=1.
  - pc<=pc+2; go to READY.
  - The buffer is guaranteed free by the issue rule.
- WAIT, redirect && !imem_valid: pc<=redirect_addr; go to DISCARD.
- WAIT, redirect && imem_valid same cycle: drop data; pc<=redirect_addr; go to READY.
- DISCARD: imem_valid drops data and goes to READY. Redirect here updates pc and stays in DISCARD.
- Consumption: inst_valid && !stall with no load this cycle clears inst_valid.
  - If the consumed inst_out[15:12]==HALT_OPCODE: go to HALTED and set halted=1 next cycle.
- HALTED: no requests. Redirect sets halted<=0, pc<=redirect_addr, and goes to READY (wrong-path HLT is cancelled).
- Redirect priority, in any state: redirect outranks stall and consumption.
  - inst_valid<=0 next cycle (buffer flushed).
  - pc<=redirect_addr.
  - No request is issued in the redirect cycle.
- imem_valid is ignored in READY and HALTED.
- Arithmetic: pc+2 wraps 16'hFFFE -> 16'h0000. redirect_addr is used as-is (bit 0 not forced).
- Throughput: at best one instruction per 2 cycles (request cycle, response cycle). Memory latency is ≥1 cycle and unbounded.
- A held stall keeps inst_out/pc_out/pc_plus2 stable, and no new request issues.

Test Plan:
- Reset, zero-latency-plus-one memory, stall=0 -> imem_req pulses with imem_addr 0x0000, 0x0002, 0x0004 every 2 cycles; inst_valid delivers each word with pc_plus2 0x0002, 0x0004, 0x0006.
- Buffer holds inst at pc 0x0010, stall=1 for 5 cycles -> no imem_req; outputs stable. Release stall -> next request addr 0x0012 the same cycle.
- Request to 0x0020 outstanding, redirect=1 to 0x0100, response arrives 3 cycles later -> response dropped, inst_valid stays 0, next imem_addr 0x0100.
- Redirect to 0x0040 in the same cycle as imem_valid in WAIT -> data dropped, no DISCARD, next request addr 0x0040 the following cycle.
- Fetch 16'hF000 at 0x0008 -> no further requests. halted=1 the cycle after consumption. Then redirect to 0x0200 -> halted=0, request 0x0200.
- PC wrap: RESET_PC=16'hFFFE -> first fetch addr 0xFFFE, pc_plus2=0x0000, next request 0x0000. Assert rst during WAIT -> inst_valid=0, pc=RESET_PC next cycle.
